// File: rtl/sram_responder.sv
// Single-port memory responder for the core load/store port: byte-masked stores,
// sign/zero-extended loads, fixed programmable latency. Define SRAM_RESP_B2B_EN for back-to-back accepts.
module sram_responder #(
   parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [7:0]  req_wmask,
   input  logic [2:0]  req_rmask,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_r;
   logic [3:0]  cnt_r;
   logic        wen_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic [3:0]  wmask_r;
   logic [2:0]  rmask_r;
   logic        req_ready_r;
   logic        resp_valid_r;
   logic [31:0] resp_rdata_r;
   logic        resp_err_r;
   logic [31:0] mem_r [DEPTH_WORDS];

   logic             accept_s;
   logic [31:0]      offset_s;
   logic [IDX_W-1:0] idx_s;
   logic             range_err_s;
   logic [7:0]       lane_en_s;
   logic [31:0]      lane_data_s;
   logic             st_err_s;
   logic             ld_err_s;
   logic [31:0]      rd_word_s;
   logic             commit_s;
   logic             unused_wmask_s;

   function automatic logic load_type_legal(input logic [2:0] rm);
      case (rm)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic load_misaligned(input logic [2:0] rm, input logic [1:0] off);
      case (rm[1:0])
         2'b01:   return off[0];
         2'b10:   return (off != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] rm,
                                                input logic [1:0] off);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (rm)
         3'b000:  return {{24{sh[7]}}, sh[7:0]};
         3'b001:  return {{16{sh[15]}}, sh[15:0]};
         3'b010:  return sh;
         3'b100:  return {24'h00_0000, sh[7:0]};
         3'b101:  return {16'h0000, sh[15:0]};
         default: return 32'h0000_0000;
      endcase
   endfunction

   assign unused_wmask_s = ^req_wmask[7:4];

`ifdef SRAM_RESP_B2B_EN
   assign req_ready = req_ready_r | ((state_r == RESP) & resp_ready);
`else
   assign req_ready = req_ready_r;
`endif
   assign accept_s   = req_valid & req_ready;
   assign resp_valid = resp_valid_r;
   assign resp_rdata = resp_rdata_r;
   assign resp_err   = resp_err_r;

   // Decode of the latched request: range, lane enables, error classes and commit strobe.
   always_comb begin
      offset_s    = addr_r - ADDR_BASE;
      idx_s       = offset_s[IDX_W+1:2];
      range_err_s = (addr_r < ADDR_BASE) || ({2'b00, offset_s[31:2]} >= 32'(DEPTH_WORDS));
      lane_en_s   = 8'({4'b0000, wmask_r} << addr_r[1:0]);
      lane_data_s = wdata_r << {addr_r[1:0], 3'b000};
      st_err_s    = range_err_s | (|lane_en_s[7:4]);
      ld_err_s    = range_err_s | ~load_type_legal(rmask_r) | load_misaligned(rmask_r, addr_r[1:0]);
      rd_word_s   = mem_r[idx_s];
      if ((state_r == WAIT) && (cnt_r == 4'd0) && wen_r && !st_err_s) begin
         commit_s = 1'b1;
      end else begin
         commit_s = 1'b0;
      end
   end

   // Word array; contents survive reset.
   always_ff @(posedge clk) begin
      if (commit_s) begin
         for (int b = 0; b < 4; b++) begin
            if (lane_en_s[b]) begin
               mem_r[idx_s][8*b +: 8] <= lane_data_s[8*b +: 8];
            end
         end
      end
   end

   // Request capture on the accept edge only.
   always_ff @(posedge clk) begin
      if (rst) begin
         wen_r   <= 1'b0;
         addr_r  <= 32'h0000_0000;
         wdata_r <= 32'h0000_0000;
         wmask_r <= 4'h0;
         rmask_r <= 3'b000;
      end else if (accept_s) begin
         wen_r   <= req_wen;
         addr_r  <= req_addr;
         wdata_r <= req_wdata;
         wmask_r <= req_wmask[3:0];
         rmask_r <= req_rmask;
      end
   end

   // Transaction FSM with registered handshake and response outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         cnt_r        <= 4'd0;
         req_ready_r  <= 1'b1;
         resp_valid_r <= 1'b0;
         resp_rdata_r <= 32'h0000_0000;
         resp_err_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  state_r     <= WAIT;
                  cnt_r       <= 4'(LATENCY);
                  req_ready_r <= 1'b0;
               end
            end
            WAIT: begin
               if (cnt_r == 4'd0) begin
                  state_r      <= RESP;
                  resp_valid_r <= 1'b1;
                  if (wen_r) begin
                     resp_err_r   <= st_err_s;
                     resp_rdata_r <= 32'h0000_0000;
                  end else begin
                     resp_err_r   <= ld_err_s;
                     resp_rdata_r <= ld_err_s ? 32'h0000_0000
                                              : load_extract(rd_word_s, rmask_r, addr_r[1:0]);
                  end
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid_r <= 1'b0;
                  resp_rdata_r <= 32'h0000_0000;
                  resp_err_r   <= 1'b0;
                  // accept_s can only be set here in the back-to-back build
                  if (accept_s) begin
                     state_r     <= WAIT;
                     cnt_r       <= 4'(LATENCY);
                     req_ready_r <= 1'b0;
                  end else begin
                     state_r     <= IDLE;
                     req_ready_r <= 1'b1;
                  end
               end
            end
            default: begin
               state_r      <= IDLE;
               cnt_r        <= 4'd0;
               req_ready_r  <= 1'b1;
               resp_valid_r <= 1'b0;
               resp_rdata_r <= 32'h0000_0000;
               resp_err_r   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: byte-level memory model, directed cases and random traffic.
module tb_sram_responder;

   localparam int          L    = 2;
   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wen = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic [7:0]  req_wmask = 8'h0;
   logic [2:0]  req_rmask = 3'b0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;

   sram_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(4096), .LATENCY(L)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .req_rmask(req_rmask),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [31:0] rd;
      logic        er;
   } exp_t;

   int          n_checks = 0;
   int          n_pass = 0;
   int          acc_cyc = 0;
   exp_t        exp_q[$];
   logic [31:0] last_rd = 32'h0;
   logic        last_er = 1'b0;
   logic [7:0]  bmem [0:63];
   logic        p_wen;
   logic [31:0] p_addr, p_wdata;
   logic [7:0]  p_wmask;
   logic [2:0]  p_rmask;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
   endtask

   // Byte-addressed reference: a request is a list of bytes touched starting at addr.
   function automatic exp_t model(input logic wen, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [7:0] wm, input logic [2:0] rm);
      exp_t        e;
      int          off;
      int          size;
      bit          sgn;
      logic        inr;
      logic [31:0] v;
      off  = int'(a[1:0]);
      inr  = (a >= BASE) && ((a - BASE) < 32'h0000_4000);
      e.rd = 32'h0;
      e.er = 1'b0;
      if (wen) begin
         e.er = !inr;
         for (int i = 0; i < 4; i++) if (wm[i] && (off + i) > 3) e.er = 1'b1;
         if (!e.er)
            for (int i = 0; i < 4; i++) if (wm[i]) bmem[int'(a - BASE) + i] = wd[8*i +: 8];
      end else begin
         case (rm)
            3'b000:  begin size = 1; sgn = 1'b1; end
            3'b001:  begin size = 2; sgn = 1'b1; end
            3'b010:  begin size = 4; sgn = 1'b0; end
            3'b100:  begin size = 1; sgn = 1'b0; end
            3'b101:  begin size = 2; sgn = 1'b0; end
            default: begin size = 0; sgn = 1'b0; end
         endcase
         if (!inr || size == 0 || (off % size) != 0) begin
            e.er = 1'b1;
         end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = bmem[int'(a - BASE) + i];
            if (sgn && size == 1) v = {{24{v[7]}}, v[7:0]};
            if (sgn && size == 2) v = {{16{v[15]}}, v[15:0]};
            e.rd = v;
         end
      end
      return e;
   endfunction

   // Compare process: every cycle a response is presented it must match the queued expectation.
   always @(negedge clk) begin
      if (!rst && resp_valid) begin
         if (exp_q.size() == 0) begin
            chk("spurious_resp_valid", 32'(resp_valid), 32'd0);
         end else begin
            chk("resp_rdata", resp_rdata, exp_q[0].rd);
            chk("resp_err", 32'(resp_err), 32'(exp_q[0].er));
`ifdef SRAM_RESP_B2B_EN
            chk("req_ready_in_resp", 32'(req_ready), 32'(resp_ready));
`else
            chk("req_ready_in_resp", 32'(req_ready), 32'd0);
`endif
            if (resp_ready) begin
               last_rd = resp_rdata;
               last_er = resp_err;
               exp_q.delete(0);
            end
         end
      end
   end

   task automatic drive_req(input logic wen, input logic [31:0] a, input logic [31:0] wd,
                            input logic [7:0] wm, input logic [2:0] rm);
      req_valid = 1'b1; req_wen = wen; req_addr = a; req_wdata = wd; req_wmask = wm; req_rmask = rm;
      p_wen = wen; p_addr = a; p_wdata = wd; p_wmask = wm; p_rmask = rm;
   endtask

   task automatic wait_accept(input bit push, output int waited);
      waited = 0;
      @(negedge clk);
      while (!req_ready && waited < 50) begin
         waited++;
         @(negedge clk);
      end
      if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      acc_cyc    = cyc;
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      req_wen    = 1'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      req_wmask  = 8'($urandom);
      req_rmask  = 3'($urandom);
      if (push) exp_q.push_back(model(p_wen, p_addr, p_wdata, p_wmask, p_rmask));
   endtask

   task automatic wait_resp(input int stall);
      int t;
      t = 0;
      @(negedge clk);
      while (!resp_valid && t < 40) begin
         t++;
         @(negedge clk);
      end
      chk("resp_latency", 32'(cyc - acc_cyc), 32'(L + 1));
      repeat (stall) @(posedge clk);
      @(posedge clk);
      #1 resp_ready = 1'b1;
   endtask

   task automatic release_resp();
      @(posedge clk);
      #1 resp_ready = 1'b0;
   endtask

   task automatic txn(input logic wen, input logic [31:0] a, input logic [31:0] wd,
                      input logic [7:0] wm, input logic [2:0] rm, input int stall);
      int w;
      drive_req(wen, a, wd, wm, rm);
      wait_accept(1'b1, w);
      wait_resp(stall);
      release_resp();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          w;
      int          r;
      logic [31:0] a;

      for (int i = 0; i < 64; i++) bmem[i] = 8'h00;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 16; i++) txn(1'b1, BASE + 32'(4 * i), 32'h0, 8'h0F, 3'b000, 0);

      // basic store then load
      txn(1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 8'h0F, 3'b000, 0);
      chk("t1_sw_err", 32'(last_er), 32'd0);
      txn(1'b0, 32'h8000_0000, 32'h0, 8'h00, 3'b010, 0);
      chk("t1_lw_rdata", last_rd, 32'hDEAD_BEEF);
      chk("t1_lw_err", 32'(last_er), 32'd0);

      // byte store and extensions
      txn(1'b1, 32'h8000_0005, 32'h0000_0080, 8'h01, 3'b000, 1);
      txn(1'b0, 32'h8000_0005, 32'h0, 8'h00, 3'b100, 0);
      chk("t2_lbu", last_rd, 32'h0000_0080);
      txn(1'b0, 32'h8000_0005, 32'h0, 8'h00, 3'b000, 0);
      chk("t2_lb", last_rd, 32'hFFFF_FF80);
      txn(1'b0, 32'h8000_0004, 32'h0, 8'h00, 3'b010, 0);
      chk("t2_lw", last_rd, 32'h0000_8000);

      // misalignment and illegal load type
      txn(1'b0, 32'h8000_0003, 32'h0, 8'h00, 3'b001, 0);
      chk("t3_lh_mis_err", 32'(last_er), 32'd1);
      chk("t3_lh_mis_rdata", last_rd, 32'h0);
      txn(1'b1, 32'h8000_0002, 32'h1111_2222, 8'h0F, 3'b000, 0);
      chk("t3_sw_mis_err", 32'(last_er), 32'd1);
      txn(1'b0, 32'h8000_0000, 32'h0, 8'h00, 3'b010, 0);
      chk("t3_word_unchanged", last_rd, 32'hDEAD_BEEF);
      txn(1'b0, 32'h8000_0000, 32'h0, 8'h00, 3'b111, 0);
      chk("t3_rmask_111_err", 32'(last_er), 32'd1);

      // range
      txn(1'b0, 32'h8000_4000, 32'h0, 8'h00, 3'b010, 0);
      chk("t4_above_err", 32'(last_er), 32'd1);
      txn(1'b0, 32'h7FFF_FFFC, 32'h0, 8'h00, 3'b010, 0);
      chk("t4_below_err", 32'(last_er), 32'd1);

      // held response, then handshake
      drive_req(1'b0, 32'h8000_0000, 32'h0, 8'h00, 3'b010);
      wait_accept(1'b1, w);
      wait_resp(5);
`ifdef SRAM_RESP_B2B_EN
      drive_req(1'b0, 32'h8000_0004, 32'h0, 8'h00, 3'b010);
      wait_accept(1'b1, w);
      chk("t5_b2b_no_bubble", 32'(w), 32'd0);
      wait_resp(0);
      release_resp();
      chk("t5_b2b_rdata", last_rd, 32'h0000_8000);
`else
      release_resp();
      @(negedge clk);
      chk("t5_idle_resp_valid", 32'(resp_valid), 32'd0);
      chk("t5_idle_req_ready", 32'(req_ready), 32'd1);
`endif
      chk("t5_held_rdata", last_rd, (`ifdef SRAM_RESP_B2B_EN 32'h0000_8000 `else 32'hDEAD_BEEF `endif));

      // reset during WAIT drops the store
      @(posedge clk);
      #1;
      drive_req(1'b1, 32'h8000_0008, 32'h1234_5678, 8'h0F, 3'b000);
      wait_accept(1'b0, w);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("t6_resp_valid", 32'(resp_valid), 32'd0);
      chk("t6_req_ready", 32'(req_ready), 32'd1);
      repeat (4) begin
         @(negedge clk);
         chk("t6_resp_valid_quiet", 32'(resp_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      txn(1'b0, 32'h8000_0008, 32'h0, 8'h00, 3'b010, 0);
      chk("t6_old_value", last_rd, 32'h0000_0000);

      // random traffic against the byte model
      for (int n = 0; n < 200; n++) begin
         r = $urandom_range(0, 9);
         if (r < 8) begin
            a = BASE + 32'($urandom_range(0, 63));
         end else begin
            case ($urandom_range(0, 3))
               0:       a = 32'h8000_4000;
               1:       a = 32'h7FFF_FFFC;
               2:       a = 32'hFFFF_FFF0;
               default: a = 32'h0000_0004;
            endcase
         end
         txn(1'($urandom), a, $urandom, 8'($urandom), 3'($urandom), $urandom_range(0, 3));
      end

      repeat (3) @(posedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
